// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop line synchroniser, oversampled mid-bit sampling of start/data/parity/stop,
// and a single-entry holding register presented through RxValid/RxReady.
module uart_rx_core #(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 SysClk,
  input  logic                 Rst,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  input  logic                 RxReady,
  output logic                 ParityErr,
  output logic                 FrameErr,
  output logic                 Overrun,
  output logic                 Busy,
  output logic [2:0]           DbgState
);
  localparam int TICK_DIV = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_W   = (TICK_DIV >= 2) ? $clog2(TICK_DIV) : 1;
  localparam int SAMP_W   = (OVERSAMPLE >= 4) ? $clog2(OVERSAMPLE) : 2;
  localparam int BIT_W    = 4;
  localparam logic ODD_BIT = 1'(PARITY_ODD);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (TICK_DIV < 2) begin : g_bad_div
    $error("uart_rx_core: TICK_DIV must be >= 2");
  end
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_os
    $error("uart_rx_core: OVERSAMPLE must be even and >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_rx_core: DATA_BITS must be in 5..9");
  end

  logic                 sync1_q, rxs_q, rxs_prev_q;
  logic [2:0]           state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [SAMP_W-1:0]    samp_q, samp_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_out_q, ferr_out_q, ovr_q;
  logic                 tick, fall, mid_start, bit_end, load;

  // Synchroniser and edge history reset high so reset release never looks like a start edge.
  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= RxD;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign tick      = (tick_q == TICK_W'(TICK_DIV - 1));
  assign fall      = rxs_prev_q && !rxs_q;
  assign mid_start = tick && (samp_q == SAMP_W'(OVERSAMPLE / 2 - 1));
  assign bit_end   = tick && (samp_q == SAMP_W'(OVERSAMPLE - 1));

  always_comb begin
    state_d = state_q;
    tick_d  = tick ? '0 : tick_q + TICK_W'(1);
    samp_d  = tick ? samp_q + SAMP_W'(1) : samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        samp_d = samp_q;
        if (fall) begin
          state_d = S_START;
          tick_d  = '0;
          samp_d  = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (mid_start) begin
          samp_d  = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          samp_d  = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          samp_d  = '0;
          perr_d  = ((^shift_q) ^ rxs_q) != ODD_BIT;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Back to IDLE at mid stop bit so the next start edge can land in its second half.
        if (bit_end) begin
          samp_d  = '0;
          ferr_d  = !rxs_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // Handshake: a word transfers on any cycle with RxValid && RxReady. A finished frame loads
  // when the register is empty or being drained that cycle; otherwise it is dropped with Overrun.
  assign load = done_q && (!valid_q || RxReady);

  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ovr_q <= done_q && valid_q && !RxReady;
      if (load) begin
        valid_q    <= 1'b1;
        data_q     <= shift_q;
        perr_out_q <= perr_q;
        ferr_out_q <= ferr_q;
      end else if (valid_q && RxReady) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign RxData    = data_q;
  assign RxValid   = valid_q;
  assign ParityErr = perr_out_q;
  assign FrameErr  = ferr_out_q;
  assign Overrun   = ovr_q;
  assign Busy      = (state_q != S_IDLE);
  assign DbgState  = state_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames plus random traffic, checked every cycle against a
// frame-level model of the holding register driven by predicted frame completion times.
module tb_uart_rx_core;
  localparam int SYSCLK_RATE = 1600000;
  localparam int BAUD_RATE   = 10000;
  localparam int OVERSAMPLE  = 16;
  localparam int DATA_BITS   = 8;
  localparam int PARITY_ODD  = 0;
  localparam int BIT_CYC     = SYSCLK_RATE / BAUD_RATE;
  // Line edge driven after negedge n -> RxValid visible after posedge n+LAT.
  localparam int LAT         = 1684;

  logic       SysClk = 1'b0;
  logic       Rst, RxD, RxReady;
  logic [7:0] RxData;
  logic       RxValid, ParityErr, FrameErr, Overrun, Busy;
  logic [2:0] DbgState;

  uart_rx_core #(
    .SYSCLK_RATE(SYSCLK_RATE), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS(DATA_BITS), .PARITY_EN(1), .PARITY_ODD(PARITY_ODD)
  ) dut (
    .SysClk(SysClk), .Rst(Rst), .RxD(RxD), .RxData(RxData), .RxValid(RxValid),
    .RxReady(RxReady), .ParityErr(ParityErr), .FrameErr(FrameErr), .Overrun(Overrun),
    .Busy(Busy), .DbgState(DbgState)
  );

  // clock / reset block
  always #5 SysClk = ~SysClk;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  ovr_cnt = 0;
  bit  check_en = 1'b0;
  bit  rand_on = 1'b0;

  // scoreboard: {due cycle, data, parity err, frame err}
  logic [41:0] exp_q[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_data = '0;
  logic       m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge SysClk) begin : model_b
    logic [41:0] f;
    cyc++;
    m_ovr = 1'b0;
    if (Rst) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_perr  = 1'b0;
      m_ferr  = 1'b0;
    end else if (exp_q.size() > 0 && exp_q[0][41:10] == cyc) begin
      f = exp_q.pop_front();
      if (!m_valid || RxReady) begin
        m_valid = 1'b1;
        m_data  = f[9:2];
        m_perr  = f[1];
        m_ferr  = f[0];
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && RxReady) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge SysClk) begin
    if (check_en && !Rst) begin
      chk("rx_valid", RxValid, m_valid);
      if (m_valid) begin
        chk("rx_data", RxData, m_data);
        chk("parity_err", ParityErr, m_perr);
        chk("frame_err", FrameErr, m_ferr);
      end
      chk("overrun", Overrun, m_ovr);
      if (Overrun) ovr_cnt++;
    end
  end

  // driver tasks
  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit stop_v);
    logic        par;
    logic        perr_e;
    logic [10:0] bits;
    par    = (^d) ^ 1'(PARITY_ODD) ^ flip_par;
    perr_e = ((^d) ^ par) != 1'(PARITY_ODD);
    exp_q.push_back({cyc + LAT, d, perr_e, !stop_v});
    bits = {stop_v, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      RxD = bits[i];
      repeat (BIT_CYC) @(negedge SysClk);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (RxValid !== 1'b1 && n < max_cyc) begin
      @(negedge SysClk);
      n++;
    end
    if (RxValid !== 1'b1) chk("valid_timeout", {31'd0, RxValid}, 32'd1);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  lat;
    int  cnt;
    logic [7:0] d;
    bit  fp, st;
    int  gap;
    Rst = 1'b1; RxD = 1'b1; RxReady = 1'b1;
    repeat (5) @(negedge SysClk);
    chk("reset_data", RxData, 8'h00);
    chk("reset_valid", RxValid, 1'b0);
    chk("reset_perr", ParityErr, 1'b0);
    chk("reset_ferr", FrameErr, 1'b0);
    chk("reset_ovr", Overrun, 1'b0);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_state", DbgState, 3'd0);
    Rst = 1'b0;
    repeat (20) @(negedge SysClk);
    check_en = 1'b1;

    // 1: clean 0xA5, latency and one-cycle valid with RxReady high
    fork
      send_frame(8'hA5, 1'b0, 1'b1);
      begin
        wait_valid(2000, lat);
        chk("t1_latency_window", {31'd0, (lat >= 1681 && lat <= 1685)}, 32'd1);
        chk("t1_data", RxData, 8'hA5);
        chk("t1_model_data", m_data, 8'hA5);
        chk("t1_perr", ParityErr, 1'b0);
        chk("t1_ferr", FrameErr, 1'b0);
        @(negedge SysClk);
        chk("t1_valid_one_cycle", RxValid, 1'b0);
      end
    join
    repeat (30) @(negedge SysClk);

    // 2: wrong parity bit
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        wait_valid(2000, lat);
        chk("t2_data", RxData, 8'hA5);
        chk("t2_perr", ParityErr, 1'b1);
        chk("t2_model_perr", m_perr, 1'b1);
        chk("t2_ferr", FrameErr, 1'b0);
      end
    join
    repeat (30) @(negedge SysClk);

    // 3: stop bit low followed by a break
    fork
      send_frame(8'h3C, 1'b0, 1'b0);
      begin
        wait_valid(2000, lat);
        chk("t3_data", RxData, 8'h3C);
        chk("t3_ferr", FrameErr, 1'b1);
      end
    join
    cnt = 0;
    repeat (1000) begin
      @(negedge SysClk);
      if (RxValid) cnt++;
    end
    chk("t3_break_no_extra", cnt, 0);
    RxD = 1'b1;
    repeat (50) @(negedge SysClk);
    fork
      send_frame(8'h3C, 1'b0, 1'b1);
      begin
        wait_valid(2000, lat);
        chk("t3_recover_data", RxData, 8'h3C);
        chk("t3_recover_ferr", FrameErr, 1'b0);
      end
    join
    repeat (30) @(negedge SysClk);

    // 4: 40-cycle glitch
    RxD = 1'b0;
    repeat (40) @(negedge SysClk);
    chk("t4_busy_during", Busy, 1'b1);
    RxD = 1'b1;
    cnt = 0;
    repeat (300) begin
      @(negedge SysClk);
      if (RxValid) cnt++;
    end
    chk("t4_no_valid", cnt, 0);
    chk("t4_busy_after", Busy, 1'b0);
    chk("t4_state_idle", DbgState, 3'd0);
    chk("t4_perr", ParityErr, 1'b0);
    chk("t4_ferr", FrameErr, 1'b0);

    // 5: back-to-back with consumer stalled
    RxReady = 1'b0;
    ovr_cnt = 0;
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    repeat (20) @(negedge SysClk);
    chk("t5_valid_held", RxValid, 1'b1);
    chk("t5_data_kept", RxData, 8'h3C);
    chk("t5_overrun_once", ovr_cnt, 1);
    RxReady = 1'b1;
    @(negedge SysClk);
    chk("t5_valid_drop", RxValid, 1'b0);
    repeat (20) @(negedge SysClk);

    // 6: reset in the middle of data bit 4 of 0xFF
    RxD = 1'b0;
    repeat (BIT_CYC) @(negedge SysClk);
    RxD = 1'b1;
    repeat (BIT_CYC * 4 + BIT_CYC / 2) @(negedge SysClk);
    chk("t6_busy_before", Busy, 1'b1);
    Rst = 1'b1;
    @(negedge SysClk);
    chk("t6_data", RxData, 8'h00);
    chk("t6_valid", RxValid, 1'b0);
    chk("t6_perr", ParityErr, 1'b0);
    chk("t6_ferr", FrameErr, 1'b0);
    chk("t6_ovr", Overrun, 1'b0);
    chk("t6_busy", Busy, 1'b0);
    repeat (3) @(negedge SysClk);
    Rst = 1'b0;
    repeat (BIT_CYC * 6) @(negedge SysClk);
    fork
      send_frame(8'h5A, 1'b0, 1'b1);
      begin
        wait_valid(2000, lat);
        chk("t6_after_data", RxData, 8'h5A);
        chk("t6_after_perr", ParityErr, 1'b0);
        chk("t6_after_ferr", FrameErr, 1'b0);
      end
    join
    repeat (30) @(negedge SysClk);

    // random traffic with random consumer stalls
    rand_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          d  = 8'($urandom_range(0, 255));
          fp = ($urandom_range(0, 3) == 0);
          st = ($urandom_range(0, 7) != 0);
          send_frame(d, fp, st);
          RxD = 1'b1;
          gap = st ? $urandom_range(0, 200) : $urandom_range(20, 200);
          repeat (gap) @(negedge SysClk);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          RxReady = ($urandom_range(0, 3) != 0);
          @(negedge SysClk);
        end
      end
    join
    RxReady = 1'b1;
    repeat (100) @(negedge SysClk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receive path. Recovers bit timing from the asynchronous serial line using an oversampled tick derived from SysClk, deframes start/data/parity/stop, and presents each byte through a valid/ready holding register. It is the receiving end of the serial link driven by the transmit path, and shares the SYSCLK_RATE/BAUD_RATE parameterisation with the design's baud timing generator.

Parameters:
SYSCLK_RATE, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate in bits/s
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 4
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY_EN, 1, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
SysClk  in  1  system clock
Rst  in  1  reset, asynchronous, active-high
RxD  in  1  serial line, asynchronous to SysClk, idles high
RxData  out  DATA_BITS  received word, LSB = first data bit on the line
RxValid  out  1  RxData and error flags are valid
RxReady  in  1  consumer accepts the word
ParityErr  out  1  parity mismatch for the current RxData
FrameErr  out  1  stop bit sampled low for the current RxData
Overrun  out  1  one-cycle pulse: a completed frame was dropped
Busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: RxData=0, RxValid=0, ParityErr=0, FrameErr=0, Overrun=0, Busy=0, FSM=IDLE, all counters 0. Synchroniser flops reset to 1 so that reset cannot produce a false start.
- RxD passes through a 2-flop synchroniser; all logic uses the synchronised value (rxs).
- Tick generation: TICK_DIV = SYSCLK_RATE/(BAUD_RATE*OVERSAMPLE), integer division. Counter runs 0..TICK_DIV-1; tick is a 1-cycle pulse on terminal count. Counter is cleared on start-edge detection. Elaboration error if TICK_DIV < 2, OVERSAMPLE is odd or < 4, or DATA_BITS is outside 5..9.
- The sample counter counts ticks within the current bit.
- IDLE: a falling edge of rxs (previous 1, current 0) moves to START and clears the tick and sample counters. A line that is low without a preceding edge is ignored.
- START: on tick OVERSAMPLE/2 (mid-bit), sample rxs. If 0, go to DATA with the sample counter reset. If 1, treat as a glitch and return to IDLE with no flags and no RxValid.
- DATA: every OVERSAMPLE ticks, sample at mid-bit and shift in LSB-first. After DATA_BITS samples, go to PARITY if PARITY_EN, else go to STOP.
- PARITY: sample one bit. Error if (XOR of data bits XOR parity bit) != PARITY_ODD.
- STOP: sample one bit; a 0 sets the frame error. Return to IDLE on the same tick, so a following start edge can be detected during the stop bit's second half.
- Hand-off: the cycle after the stop sample, if RxValid=0 or RxReady=1, load RxData, ParityErr and FrameErr, and set RxValid=1. If RxValid=1 and RxReady=0, discard the new frame, keep the old contents, and pulse Overrun for 1 cycle.
- RxValid clears on the cycle after RxValid&&RxReady, unless a new frame loads in that same cycle; in that case it stays 1 with the new data. Flags are only meaningful while RxValid=1.
- Frames with FrameErr or ParityErr are still delivered.
- A break condition (line held low) yields one frame with FrameErr and no further frames until the line returns high.
- Latency: RxValid rises 2 (synchroniser) + 1 cycles after the stop-bit mid sample.
- Rst mid-frame: immediate return to reset state and the partial frame is lost. The next frame needs a fresh falling edge.

Test Plan:
Common setup: SYSCLK_RATE=1600000, BAUD_RATE=10000, OVERSAMPLE=16, so TICK_DIV=10 and one bit = 160 cycles. DATA_BITS=8, PARITY_EN=1, PARITY_ODD=0.
1. Send 0xA5 with parity 0 and stop 1, RxReady=1 -> RxData=0xA5, RxValid high 1 cycle, ParityErr=0, FrameErr=0, RxValid at edge+1683 +/-2 cycles.
2. Send 0xA5 with parity 1 -> RxData=0xA5, RxValid=1, ParityErr=1, FrameErr=0.
3. Send 0x3C with stop bit 0, then hold the line low 1000 cycles -> one RxValid with FrameErr=1, then no further RxValid until the line goes high and a new 0x3C frame arrives.
4. Pulse RxD low for 40 cycles (shorter than the 80-cycle mid-start sample) -> no RxValid, Busy returns to 0, no flags.
5. Hold RxReady=0 and send 0x3C then 0xC3 back-to-back -> RxData stays 0x3C, Overrun pulses exactly once. Then raise RxReady -> RxValid drops the next cycle.
6. Assert Rst during data bit 4 of 0xFF -> all outputs 0 and Busy=0. After release, send 0x5A -> RxData=0x5A with no errors.
